// File: rtl/ram_1p_pipe.sv
// ram_1p_pipe: parametrised single-port SRAM slave for the ibex instruction/data bus.
// After reset the array is walked once and zero-filled, and no request is granted
// until that completes. Once init_done is high the slave accepts one request per
// cycle. Every accepted request, read or write, gets exactly one in-order response
// ReadLatency cycles later. A word index at or beyond Depth drops the write, reads
// as zero and returns err.
//
// Build option RAM_PARITY_EN: each byte also stores an even-parity bit. A parity
// mismatch on a read raises err, and the stored data is still returned. When the
// macro is undefined, err reports the range check only.
module ram_1p_pipe #(
  parameter int DataWidth   = 32,
  parameter int Depth       = 128,
  parameter int ReadLatency = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [DataWidth/8-1:0] i_be,
  input  logic [31:0]            i_addr,
  input  logic [DataWidth-1:0]   i_wdata,
  output logic                   o_gnt,
  output logic                   o_rvalid,
  output logic [DataWidth-1:0]   o_rdata,
  output logic                   o_err,
  output logic                   o_init_done
);

  localparam int NumBytes = DataWidth / 8;
  localparam int AddrLsb  = $clog2(NumBytes);
  localparam int IdxW     = $clog2(Depth);
  localparam int WordW    = 32 - AddrLsb;

  // Word-index bound, and the last index written during the clear walk
  localparam logic [WordW-1:0] DepthW  = WordW'(Depth);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(Depth - 1);
  localparam logic [IdxW-1:0]  IdxOne  = IdxW'(1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Sequencer state
  state_t              r_state;
  logic [IdxW-1:0]     r_init_cnt;
  logic                r_init_done;

  // Storage
  logic [DataWidth-1:0] r_mem [Depth];
`ifdef RAM_PARITY_EN
  logic [NumBytes-1:0]  r_par [Depth];
`endif

  // Response pipeline: stage 0 is the array output register
  logic [ReadLatency-1:0] r_pv;
  logic [DataWidth-1:0]   r_pd [ReadLatency];
  logic [ReadLatency-1:0] r_pe;

  // Request decode
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_wr_en;
  logic                 w_init_we;
  logic [WordW-1:0]     w_word;
  logic [IdxW-1:0]      w_idx;
  logic [DataWidth-1:0] w_rd_word;
  logic [DataWidth-1:0] w_resp_data;
  logic                 w_par_err;
  logic                 w_resp_err;

`ifdef RAM_PARITY_EN
  logic [NumBytes-1:0]  w_wr_par;

  // Even parity per byte: each bit makes its byte plus the parity bit hold an even count of ones
  function automatic logic [NumBytes-1:0] f_byte_parity(input logic [DataWidth-1:0] d);
    logic [NumBytes-1:0] p;
    p = {NumBytes{1'b0}};
    for (int b = 0; b < NumBytes; b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction

  assign w_wr_par = f_byte_parity(i_wdata);
`endif

  // The sub-word byte offset is not used for word selection
  generate
    if (AddrLsb > 0) begin : g_addr_lsb
      logic w_unused_addr_lsb;
      assign w_unused_addr_lsb = ^i_addr[AddrLsb-1:0];
    end
  endgenerate

  assign w_word     = i_addr[31:AddrLsb];
  assign w_idx      = w_word[IdxW-1:0];
  assign w_in_range = (w_word < DepthW);
  assign w_ready    = (r_state == ST_READY);
  assign w_accept   = i_req & w_ready & ~i_rst;
  assign w_wr_en    = w_accept & i_we & w_in_range;
  assign w_init_we  = (r_state == ST_INIT) & ~i_rst;

  // Grant is combinational so that a request can be accepted in the cycle it is presented
  assign o_gnt = w_accept;

  // Clear sequencer: walk every word once after reset, then stay ready until the next reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= {IdxW{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == LastIdx) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt  <= r_init_cnt + IdxOne;
          end
        end
        ST_READY: begin
          r_state     <= ST_READY;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_INIT;
          r_init_cnt  <= {IdxW{1'b0}};
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: zero-fill during the clear walk, byte-masked writes once ready
  always_ff @(posedge i_clk) begin
    if (w_init_we) begin
      r_mem[r_init_cnt] <= {DataWidth{1'b0}};
`ifdef RAM_PARITY_EN
      r_par[r_init_cnt] <= {NumBytes{1'b0}};
`endif
    end else if (w_wr_en) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (i_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
`ifdef RAM_PARITY_EN
          r_par[w_idx][b]        <= w_wr_par[b];
`endif
        end
      end
    end
  end

  // Read-first array access and formation of the response for this request
  always_comb begin
    w_rd_word   = {DataWidth{1'b0}};
    w_par_err   = 1'b0;
    w_resp_data = {DataWidth{1'b0}};
    w_resp_err  = 1'b0;
    if (w_in_range) begin
      w_rd_word = r_mem[w_idx];
`ifdef RAM_PARITY_EN
      w_par_err = |(f_byte_parity(r_mem[w_idx]) ^ r_par[w_idx]);
`else
      w_par_err = 1'b0;
`endif
    end else begin
      w_rd_word = {DataWidth{1'b0}};
      w_par_err = 1'b0;
    end
    if (i_we) begin
      w_resp_data = {DataWidth{1'b0}};
      w_resp_err  = ~w_in_range;
    end else begin
      w_resp_data = w_rd_word;
      w_resp_err  = ~w_in_range | w_par_err;
    end
  end

  // Response pipeline: array register followed by ReadLatency-1 delay stages, zeroed when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < ReadLatency; k++) begin
        r_pv[k] <= 1'b0;
        r_pd[k] <= {DataWidth{1'b0}};
        r_pe[k] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= w_accept ? w_resp_data : {DataWidth{1'b0}};
      r_pe[0] <= w_accept & w_resp_err;
      for (int k = 1; k < ReadLatency; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pd[k] <= r_pd[k-1];
        r_pe[k] <= r_pe[k-1];
      end
    end
  end

  // Output drive: the last pipeline stage, held at zero while reset is asserted
  always_comb begin
    o_rvalid    = 1'b0;
    o_rdata     = {DataWidth{1'b0}};
    o_err       = 1'b0;
    o_init_done = 1'b0;
    if (i_rst) begin
      o_rvalid    = 1'b0;
      o_rdata     = {DataWidth{1'b0}};
      o_err       = 1'b0;
      o_init_done = 1'b0;
    end else begin
      o_rvalid    = r_pv[ReadLatency-1];
      o_rdata     = r_pd[ReadLatency-1];
      o_err       = r_pe[ReadLatency-1];
      o_init_done = r_init_done;
    end
  end

endmodule

// File: tb/tb_ram_1p_pipe.sv
// Bench for ram_1p_pipe with DataWidth=32, Depth=128, ReadLatency=2.
// Directed stimulus pushes hand-computed responses into a queue, and a monitor pops and compares them.
module tb_ram_1p_pipe;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [3:0]    i_be = 4'h0;
  logic [31:0]   i_addr = 32'h0;
  logic [DW-1:0] i_wdata = 32'h0;
  logic          o_gnt, o_rvalid, o_err, o_init_done;
  logic [DW-1:0] o_rdata;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int tagn   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    int          tag;
  } exp_t;
  exp_t q[$];

  ram_1p_pipe #(.DataWidth(DW), .Depth(DEPTH), .ReadLatency(RL)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_be(i_be),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_err(o_err), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every response is matched in order against the queue, including its arrival cycle
  always @(negedge clk) begin
    exp_t e;
    if (o_rvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=0x%08h expected no response (cycle %0d)", o_rdata, cyc);
      end else begin
        e = q.pop_front();
        chk($sformatf("rdata#%0d", e.tag), o_rdata, e.data);
        chk($sformatf("err#%0d", e.tag), 32'(o_err), 32'(e.err));
        chk($sformatf("latency#%0d", e.tag), 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_rdata", o_rdata, 32'h0);
      chk("idle_err", 32'(o_err), 32'h0);
    end
  end

  task automatic idle();
    i_req = 1'b0; i_we = 1'b0; i_be = 4'h0; i_addr = 32'h0; i_wdata = 32'h0;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] edata, input logic eerr);
    exp_t e;
    i_req = 1'b1; i_we = we; i_be = be; i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    chk($sformatf("gnt#%0d", tagn), 32'(o_gnt), 32'h1);
    if (o_gnt) begin
      e.data = edata; e.err = eerr; e.due = cyc + RL; e.tag = tagn;
      q.push_back(e);
    end
    tagn++;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  // The clear walk holds gnt low for DEPTH cycles, even with a request pending
  task automatic wait_init();
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("init_gnt", 32'(o_gnt), 32'h0);
      chk("init_done_low", 32'(o_init_done), 32'h0);
    end
    i_req = 1'b0;
    @(negedge clk);
    chk("init_done_high", 32'(o_init_done), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse(input int n);
    i_rst = 1'b1;
    idle();
    q.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_rvalid", 32'(o_rvalid), 32'h0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_err", 32'(o_err), 32'h0);
      chk("rst_init_done", 32'(o_init_done), 32'h0);
      @(posedge clk); #1;
    end
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] par_exp_data;
    logic        par_exp_err;
    @(posedge clk); #1;
    // 1: reset, clear walk, read the last word
    reset_pulse(3);
    wait_init();
    issue(1'b0, 4'h0, 32'h0000_01FC, 32'h0, 32'h0000_0000, 1'b0);
    drain();

    // 2: full write then byte-1 write to the same word, read immediately after
    issue(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(1'b1, 4'h2, 32'h0000_0010, 32'h0000_5500, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 1'b0);
    drain();

    // 3: preload 1..4, then four back-to-back reads
    issue(1'b1, 4'hF, 32'h0000_0000, 32'h1, 32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h0000_0004, 32'h2, 32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h0000_0008, 32'h3, 32'h0, 1'b0);
    issue(1'b1, 4'hF, 32'h0000_000C, 32'h4, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h1, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0004, 32'h0, 32'h2, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'h3, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_000C, 32'h0, 32'h4, 1'b0);
    // be=0 is a no-op write; the byte offset is ignored on reads
    issue(1'b1, 4'h0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0004, 32'h0, 32'h2, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_000B, 32'h0, 32'h3, 1'b0);
    drain();

    // 4: range boundary: last word is valid, index 128 and above are not
    issue(1'b1, 4'hF, 32'h0000_01FC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_01FC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    issue(1'b1, 4'hF, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h1, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
    drain();

    // 5: one-cycle reset with two reads in flight, then the contents read back as zero
    issue(1'b0, 4'h0, 32'h0000_01FC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 1'b0);
    reset_pulse(1);
    wait_init();
    issue(1'b0, 4'h0, 32'h0000_01FC, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
    drain();

    // 6: parity. With parity storage, a flipped stored bit 3 is flagged on read
    issue(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0);
    drain();
`ifdef RAM_PARITY_EN
    dut.r_mem[8][3] = ~dut.r_mem[8][3];
    par_exp_data = 32'h1234_5670;
    par_exp_err  = 1'b1;
`else
    par_exp_data = 32'h1234_5678;
    par_exp_err  = 1'b0;
`endif
    issue(1'b0, 4'h0, 32'h0000_0020, 32'h0, par_exp_data, par_exp_err);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
